ipsl_pcie_dma_ram_rd_stream: RTL and testbench

Read-side engine for the PCIe DMA buffer RAM, a 128-bit simple dual-port RAM with a 12-bit line address and unregistered output (one-cycle read latency, read clock enable). It accepts a request giving a start DW address and a length, issues line reads to the RAM, and streams the returned 128-bit lines to the TLP/completion builder over a valid/ready interface. The stream carries SOP/EOP flags and per-DW enables. The RAM's read clock enable stalls the RAM output, so the RAM output itself is the stream holding register.

---
 rtl/ipsl_pcie_dma_defines.sv | 15 +
 rtl/ipsl_pcie_dma_dw_mask.sv | 29 ++
 rtl/ipsl_pcie_dma_ram_rd_stream.sv | 166 ++++++++++++++++
 tb/tb_ipsl_pcie_dma_ram_rd_stream.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipsl_pcie_dma_defines.sv
// Shared definitions for the PCIe DMA buffer RAM engines.
// Holds line geometry (4 DW per 128-bit line), the maximum request length
// and the read-stream FSM state encoding.
package ipsl_pcie_dma_defines;

    localparam int unsigned DW_PER_LINE    = 4;
    localparam int unsigned LINE_OFF_WIDTH = 2;
    localparam int unsigned MAX_LEN_DW     = 1024;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } rd_state_e;

endpackage

// File: rtl/ipsl_pcie_dma_dw_mask.sv
// Per-DW enable mask for one 128-bit RAM line.
//   off      : DW offset of the first valid DW (used when is_first)
//   end_dw   : DW index of the last valid DW (used when is_last)
//   is_first : line is the first line of the transfer
//   is_last  : line is the last line of the transfer
//   dw_en    : bit i set when DW i of the line belongs to the transfer
// Purely combinational; also intended for the write-side byte-enable path.
module ipsl_pcie_dma_dw_mask
    import ipsl_pcie_dma_defines::*;
(
    input  logic [LINE_OFF_WIDTH-1:0] off,
    input  logic [LINE_OFF_WIDTH-1:0] end_dw,
    input  logic                      is_first,
    input  logic                      is_last,
    output logic [DW_PER_LINE-1:0]    dw_en
);

    localparam logic [DW_PER_LINE-1:0] AllOnes = {DW_PER_LINE{1'b1}};

    logic [DW_PER_LINE-1:0] first_mask;
    logic [DW_PER_LINE-1:0] last_mask;

    always_comb begin
        first_mask = AllOnes << off;
        last_mask  = AllOnes >> (LINE_OFF_WIDTH'(DW_PER_LINE - 1) - end_dw);
        dw_en      = (is_first ? first_mask : AllOnes) & (is_last ? last_mask : AllOnes);
    end

endmodule

// File: rtl/ipsl_pcie_dma_ram_rd_stream.sv
// Read-side engine for the PCIe DMA buffer RAM.
// Accepts a (start DW address, length) request, issues one RAM line read per
// clock and streams the returned lines with SOP/EOP and per-DW enables.
// The RAM output is used directly as the stream holding register: the RAM
// read clock enable is dropped while a beat is stalled.
//   clk, rst_n                  : clock (shared with RAM rd_clk), async active-low reset
//   req_valid/req_ready         : request handshake
//   req_dw_addr, req_len        : start DW address and length in DW (0 = 1024)
//   ram_rd_addr, ram_rd_clk_en  : RAM read port control
//   ram_rd_data                 : RAM read data (one-cycle latency)
//   tx_data/dw_en/sop/eop       : stream beat
//   tx_valid/tx_ready           : stream handshake
//   busy                        : request issuing or beat outstanding
module ipsl_pcie_dma_ram_rd_stream
    import ipsl_pcie_dma_defines::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned LEN_WIDTH  = 10
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [ADDR_WIDTH+LINE_OFF_WIDTH-1:0] req_dw_addr,
    input  logic [LEN_WIDTH-1:0]                 req_len,
    output logic [ADDR_WIDTH-1:0]                ram_rd_addr,
    output logic                                 ram_rd_clk_en,
    input  logic [DATA_WIDTH-1:0]                ram_rd_data,
    output logic [DATA_WIDTH-1:0]                tx_data,
    output logic [DW_PER_LINE-1:0]               tx_dw_en,
    output logic                                 tx_sop,
    output logic                                 tx_eop,
    output logic                                 tx_valid,
    input  logic                                 tx_ready,
    output logic                                 busy
);

    // Wide enough for 1024 DW and for the beat count (max 257).
    localparam int unsigned CntW = LEN_WIDTH + 1;

    rd_state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]     line_addr_q, line_addr_d;
    logic [CntW-1:0]           beats_q, beats_d;
    logic [LINE_OFF_WIDTH-1:0] off_q, off_d;
    logic [LINE_OFF_WIDTH-1:0] end_q, end_d;
    logic                      first_q, first_d;

    logic                      tx_valid_q;
    logic                      tx_sop_q;
    logic                      tx_eop_q;
    logic [DW_PER_LINE-1:0]    tx_dw_en_q;

    logic                      clk_en;
    logic                      issuing;
    logic                      is_last;
    logic [DW_PER_LINE-1:0]    line_mask;

    logic [LINE_OFF_WIDTH-1:0] req_off;
    logic [CntW-1:0]           len_eff;
    logic [CntW-1:0]           beats_sum;
    logic [CntW-1:0]           beats_init;
    logic [LINE_OFF_WIDTH-1:0] end_init;

    // Everything downstream of the accept advances only when the RAM output
    // may change, so a stalled beat is never overwritten.
    assign clk_en  = ~tx_valid_q | tx_ready;
    assign issuing = (state_q == ST_ISSUE) & clk_en;
    assign is_last = (beats_q == CntW'(1));

    // Request decode, only meaningful at accept.
    always_comb begin
        req_off    = req_dw_addr[LINE_OFF_WIDTH-1:0];
        len_eff    = (req_len == '0) ? CntW'(MAX_LEN_DW) : CntW'(req_len);
        beats_sum  = CntW'(req_off) + len_eff + CntW'(DW_PER_LINE - 1);
        beats_init = beats_sum >> LINE_OFF_WIDTH;
        end_init   = req_off + len_eff[LINE_OFF_WIDTH-1:0] - LINE_OFF_WIDTH'(1);
    end

    always_comb begin
        state_d     = state_q;
        line_addr_d = line_addr_q;
        beats_d     = beats_q;
        off_d       = off_q;
        end_d       = end_q;
        first_d     = first_q;
        unique case (state_q)
            ST_IDLE: begin
                // Accept does not wait for clk_en: a stalled last beat of the
                // previous request is untouched, the first issue simply waits.
                if (req_valid) begin
                    line_addr_d = req_dw_addr[ADDR_WIDTH+LINE_OFF_WIDTH-1:LINE_OFF_WIDTH];
                    beats_d     = beats_init;
                    off_d       = req_off;
                    end_d       = end_init;
                    first_d     = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (clk_en) begin
                    line_addr_d = line_addr_q + ADDR_WIDTH'(1);
                    beats_d     = beats_q - CntW'(1);
                    first_d     = 1'b0;
                    if (is_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            line_addr_q <= '0;
            beats_q     <= '0;
            off_q       <= '0;
            end_q       <= '0;
            first_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_addr_q <= line_addr_d;
            beats_q     <= beats_d;
            off_q       <= off_d;
            end_q       <= end_d;
            first_q     <= first_d;
        end
    end

    ipsl_pcie_dma_dw_mask u_dw_mask (
        .off      (off_q),
        .end_dw   (end_q),
        .is_first (first_q),
        .is_last  (is_last),
        .dw_en    (line_mask)
    );

    // Side-band pipeline: registered on the same edge the RAM samples the
    // line address, so it lines up with ram_rd_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_valid_q <= 1'b0;
            tx_sop_q   <= 1'b0;
            tx_eop_q   <= 1'b0;
            tx_dw_en_q <= '0;
        end else if (clk_en) begin
            tx_valid_q <= issuing;
            tx_sop_q   <= issuing & first_q;
            tx_eop_q   <= issuing & is_last;
            tx_dw_en_q <= issuing ? line_mask : '0;
        end
    end

    assign req_ready     = (state_q == ST_IDLE);
    assign ram_rd_addr   = line_addr_q;
    assign ram_rd_clk_en = clk_en;
    assign tx_data       = ram_rd_data;
    assign tx_valid      = tx_valid_q;
    assign tx_sop        = tx_sop_q;
    assign tx_eop        = tx_eop_q;
    assign tx_dw_en      = tx_dw_en_q;
    assign busy          = (state_q == ST_ISSUE) | tx_valid_q;

endmodule

// File: tb/tb_ipsl_pcie_dma_ram_rd_stream.sv
module tb_ipsl_pcie_dma_ram_rd_stream;

    typedef struct packed {
        logic [127:0] data;
        logic [3:0]   dw_en;
        logic         sop;
        logic         eop;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [13:0]  req_dw_addr;
    logic [9:0]   req_len;
    logic [11:0]  ram_rd_addr;
    logic         ram_rd_clk_en;
    logic [127:0] ram_rd_data;
    logic [127:0] tx_data;
    logic [3:0]   tx_dw_en;
    logic         tx_sop;
    logic         tx_eop;
    logic         tx_valid;
    logic         tx_ready;
    logic         busy;

    int checks = 0;
    int errors = 0;

    logic [127:0] mem [4096];
    logic [127:0] ram_q;

    beat_t       obs[$];
    beat_t       exp_q[$];
    logic [11:0] iss[$];
    logic [11:0] exp_iss[$];

    beat_t cur_beat;
    beat_t prev_beat;
    logic  prev_stall;
    int    stab_err;
    logic  rnd_done;

    always #5 clk = ~clk;

    ipsl_pcie_dma_ram_rd_stream dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_dw_addr   (req_dw_addr),
        .req_len       (req_len),
        .ram_rd_addr   (ram_rd_addr),
        .ram_rd_clk_en (ram_rd_clk_en),
        .ram_rd_data   (ram_rd_data),
        .tx_data       (tx_data),
        .tx_dw_en      (tx_dw_en),
        .tx_sop        (tx_sop),
        .tx_eop        (tx_eop),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .busy          (busy)
    );

    // RAM model: unregistered output, one-cycle latency, read clock enable.
    always @(posedge clk) begin
        if (ram_rd_clk_en) ram_q <= mem[ram_rd_addr];
    end
    assign ram_rd_data = ram_q;

    assign cur_beat = {tx_data, tx_dw_en, tx_sop, tx_eop};

    // Monitor: accepted beats, issued line addresses, stalled-beat stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (tx_valid && tx_ready) obs.push_back(cur_beat);
            if (!req_ready && ram_rd_clk_en) iss.push_back(ram_rd_addr);
            if (prev_stall && (!tx_valid || cur_beat !== prev_beat)) stab_err <= stab_err + 1;
            prev_stall <= tx_valid && !tx_ready;
            prev_beat  <= cur_beat;
        end
    end

    // Reference: each DW position of the transfer is mapped onto lines/lanes.
    function automatic void add_exp(input logic [13:0] a, input logic [9:0] l);
        int len, off, line, nb, p;
        beat_t b;
        len  = (l == 0) ? 1024 : int'(l);
        off  = int'(a[1:0]);
        line = int'(a[13:2]);
        nb   = (off + len + 3) / 4;
        for (int k = 0; k < nb; k++) begin
            b.data = mem[(line + k) % 4096];
            for (int i = 0; i < 4; i++) begin
                p = k * 4 + i - off;
                b.dw_en[i] = (p >= 0) && (p < len);
            end
            b.sop = (k == 0);
            b.eop = (k == nb - 1);
            exp_q.push_back(b);
            exp_iss.push_back(12'((line + k) % 4096));
        end
    endfunction

    function automatic void clear_q();
        obs.delete();
        exp_q.delete();
        iss.delete();
        exp_iss.delete();
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic send_req(input logic [13:0] a, input logic [9:0] l);
        int n = 0;
        req_valid   = 1'b1;
        req_dw_addr = a;
        req_len     = l;
        while (req_ready !== 1'b1 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL req_accept timeout got req_ready=%b want 1", req_ready);
        end
        @(posedge clk); #1;
        req_valid   = 1'b0;
        req_dw_addr = 14'($urandom);
        req_len     = 10'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while (busy !== 1'b0 && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 5000) begin
            errors++;
            $display("FAIL done_timeout got busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; req_valid = 1'b0; req_dw_addr = '0; req_len = '0; tx_ready = 1'b0;
        stab_err = 0;
        #3 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({req_ready, tx_valid, tx_sop, tx_eop, tx_dw_en, busy, ram_rd_clk_en} !== 10'b1000000001) begin
            errors++;
            $display("FAIL reset_flags got rdy=%b v=%b sop=%b eop=%b en=%b busy=%b ce=%b want 1 0 0 0 0000 0 1",
                     req_ready, tx_valid, tx_sop, tx_eop, tx_dw_en, busy, ram_rd_clk_en);
        end
        checks++;
        if (ram_rd_addr !== 12'h000) begin
            errors++;
            $display("FAIL reset_addr got %h want 000", ram_rd_addr);
        end
        rst_n = 1'b1;
        tx_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset got rdy=%b busy=%b v=%b want 1 0 0", req_ready, busy, tx_valid);
        end
    endtask

    task automatic test_single_beat();
        clear_q();
        add_exp(14'h0006, 10'd1);
        send_req(14'h0006, 10'd1);
        wait_done();
        checks++;
        if (iss.size() != 1 || iss[0] !== 12'h001) begin
            errors++;
            $display("FAIL single_issue got n=%0d addr=%h want n=1 addr=001", iss.size(), iss[0]);
        end
        checks++;
        if (obs.size() != 1 || obs[0] !== {mem[1], 4'b0100, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL single_beat got n=%0d %h want n=1 %h", obs.size(), obs[0], {mem[1], 4'b0100, 2'b11});
        end
    endtask

    task automatic test_aligned();
        clear_q();
        add_exp(14'h0010, 10'd8);
        send_req(14'h0010, 10'd8);
        checks++;
        if (tx_valid !== 1'b0 || ram_rd_addr !== 12'h004) begin
            errors++;
            $display("FAIL aligned_issue_cycle got v=%b addr=%h want 0 004", tx_valid, ram_rd_addr);
        end
        @(posedge clk); #1;
        checks++;
        if (tx_valid !== 1'b1 || tx_sop !== 1'b1) begin
            errors++;
            $display("FAIL aligned_latency got v=%b sop=%b want 1 1", tx_valid, tx_sop);
        end
        wait_done();
        checks++;
        if (iss != exp_iss) begin
            errors++;
            $display("FAIL aligned_issue got %p want %p", iss, exp_iss);
        end
        checks++;
        if (obs.size() != exp_q.size()) begin
            errors++;
            $display("FAIL aligned_count got %0d want %0d", obs.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= obs.size() || obs[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL aligned_beat%0d got %h want %h", i, obs[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_unaligned();
        logic [3:0] want_en [3];
        want_en[0] = 4'b1000; want_en[1] = 4'b1111; want_en[2] = 4'b0001;
        clear_q();
        add_exp(14'h0003, 10'd6);
        send_req(14'h0003, 10'd6);
        wait_done();
        checks++;
        if (iss != exp_iss) begin
            errors++;
            $display("FAIL unaligned_issue got %p want %p", iss, exp_iss);
        end
        checks++;
        if (obs.size() != 3) begin
            errors++;
            $display("FAIL unaligned_count got %0d want 3", obs.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= obs.size() || obs[i] !== exp_q[i] || obs[i].dw_en !== want_en[i]) begin
                errors++;
                $display("FAIL unaligned_beat%0d got %h want %h", i, obs[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        beat_t held;
        int n = 0;
        clear_q();
        stab_err = 0;
        add_exp(14'h0040, 10'd16);
        send_req(14'h0040, 10'd16);
        while (!(tx_valid === 1'b1 && tx_sop === 1'b0) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        held = cur_beat;
        tx_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (ram_rd_clk_en !== 1'b0 || tx_valid !== 1'b1 || cur_beat !== held || held !== exp_q[1]) begin
                errors++;
                $display("FAIL bp_hold%0d got ce=%b v=%b %h want ce=0 v=1 %h", k, ram_rd_clk_en, tx_valid,
                         cur_beat, exp_q[1]);
            end
            @(posedge clk); #1;
        end
        tx_ready = 1'b1;
        wait_done();
        checks++;
        if (obs.size() != 4 || iss != exp_iss || stab_err != 0) begin
            errors++;
            $display("FAIL bp_count got beats=%0d issues=%0d stab=%0d want 4 4 0", obs.size(), iss.size(), stab_err);
        end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= obs.size() || obs[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_beat%0d got %h want %h", i, obs[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_wrap_max();
        int eops = 0;
        clear_q();
        add_exp(14'h3FFE, 10'd4);
        send_req(14'h3FFE, 10'd4);
        wait_done();
        checks++;
        if (iss.size() != 2 || iss[0] !== 12'hFFF || iss[1] !== 12'h000) begin
            errors++;
            $display("FAIL wrap_issue got %p want FFF 000", iss);
        end
        checks++;
        if (obs.size() != 2 || obs[0].dw_en !== 4'b1100 || obs[1].dw_en !== 4'b0011 || obs != exp_q) begin
            errors++;
            $display("FAIL wrap_beats got %p want %p", obs, exp_q);
        end
        clear_q();
        add_exp(14'h0000, 10'd0);
        send_req(14'h0000, 10'd0);
        wait_done();
        checks++;
        if (obs.size() != 256) begin
            errors++;
            $display("FAIL maxlen_count got %0d want 256", obs.size());
        end
        foreach (obs[i]) if (obs[i].eop) eops++;
        checks++;
        if (eops != 1 || obs.size() < 256 || obs[255].eop !== 1'b1) begin
            errors++;
            $display("FAIL maxlen_eop got eops=%0d want 1 on beat 255", eops);
        end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= obs.size() || obs[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL maxlen_beat%0d got %h want %h", i, obs[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_q();
        add_exp(14'h0100, 10'd4);
        add_exp(14'h0200, 10'd8);
        send_req(14'h0100, 10'd4);
        @(posedge clk); #1;
        tx_ready = 1'b0;
        send_req(14'h0200, 10'd8);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (ram_rd_clk_en !== 1'b0 || tx_valid !== 1'b1 || cur_beat !== exp_q[0]) begin
                errors++;
                $display("FAIL b2b_stall%0d got ce=%b v=%b %h want ce=0 v=1 %h", k, ram_rd_clk_en, tx_valid,
                         cur_beat, exp_q[0]);
            end
            @(posedge clk); #1;
        end
        tx_ready = 1'b1;
        wait_done();
        checks++;
        if (iss != exp_iss) begin
            errors++;
            $display("FAIL b2b_issue got %p want %p", iss, exp_iss);
        end
        checks++;
        if (obs != exp_q) begin
            errors++;
            $display("FAIL b2b_beats got %p want %p", obs, exp_q);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        clear_q();
        send_req(14'h0400, 10'd40);
        while (!(obs.size() == 3 && tx_valid === 1'b1) && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, tx_valid, tx_sop, tx_eop, tx_dw_en, busy, ram_rd_clk_en} !== 10'b1000000001
            || ram_rd_addr !== 12'h000) begin
            errors++;
            $display("FAIL midreset_vals got rdy=%b v=%b sop=%b eop=%b en=%b busy=%b ce=%b addr=%h want 1 0 0 0 0000 0 1 000",
                     req_ready, tx_valid, tx_sop, tx_eop, tx_dw_en, busy, ram_rd_clk_en, ram_rd_addr);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        clear_q();
        add_exp(14'h0020, 10'd4);
        send_req(14'h0020, 10'd4);
        wait_done();
        checks++;
        if (obs != exp_q || iss != exp_iss || obs.size() != 1 || obs[0].sop !== 1'b1) begin
            errors++;
            $display("FAIL midreset_next got %p want %p", obs, exp_q);
        end
    endtask

    task automatic test_random();
        clear_q();
        stab_err = 0;
        rnd_done = 1'b0;
        fork
            begin
                for (int r = 0; r < 30; r++) begin
                    logic [13:0] a;
                    logic [9:0]  l;
                    a = 14'($urandom);
                    l = ($urandom_range(0, 9) == 0) ? 10'd0 : 10'($urandom_range(1, 40));
                    if (l == 0) l = ($urandom_range(0, 1) == 0) ? 10'd0 : 10'd1;
                    add_exp(a, l);
                    send_req(a, l);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    tx_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
            end
        join
        tx_ready = 1'b1;
        wait_done();
        checks++;
        if (obs.size() != exp_q.size() || iss != exp_iss || stab_err != 0) begin
            errors++;
            $display("FAIL rnd_count got beats=%0d issues=%0d stab=%0d want beats=%0d issues=%0d stab=0",
                     obs.size(), iss.size(), stab_err, exp_q.size(), exp_iss.size());
        end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= obs.size() || obs[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rnd_beat%0d got %h want %h", i, obs[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        test_reset();
        test_single_beat();
        test_aligned();
        test_unaligned();
        test_backpressure();
        test_wrap_max();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
